// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: datapath width,
// 4-bit op codes and the arbiter FSM states.
package alu_arbiter_pkg;

    localparam int ALU_W = 32;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_SLT  = 4'd3;
    localparam logic [3:0] OP_SLTU = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_AND  = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Team ALU: purely combinational, ops 10-15 yield zero and raise illegal.
// The unsign input forces the unsigned variant of SLT and SRA.
module alu
    import alu_arbiter_pkg::*;
(
    input  logic [3:0]       op,
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    input  logic             unsign,
    output logic [ALU_W-1:0] result,
    output logic             illegal
);

    logic [4:0]       shamt;
    logic             lt_signed;
    logic             lt_unsigned;
    logic [ALU_W-1:0] sra_res;

    assign shamt       = b[4:0];
    assign lt_signed   = $signed(a) < $signed(b);
    assign lt_unsigned = a < b;
    // Kept as its own assignment so the arithmetic shift stays signed.
    assign sra_res     = $signed(a) >>> shamt;

    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_SLL:  result = a << shamt;
            OP_SLT:  result = {{(ALU_W-1){1'b0}}, (unsign ? lt_unsigned : lt_signed)};
            OP_SLTU: result = {{(ALU_W-1){1'b0}}, lt_unsigned};
            OP_XOR:  result = a ^ b;
            OP_SRL:  result = a >> shamt;
            OP_SRA:  result = unsign ? (a >> shamt) : sra_res;
            OP_OR:   result = a | b;
            OP_AND:  result = a & b;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin arbiter with one-hot grant; the last-grant pointer
// moves only when a grant is actually issued (grant implies acceptance).
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    logic last;

    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                grant = last ? 2'b01 : 2'b10;
            end else begin
                grant = req;
            end
        end
    end

    // Pointer resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= 1'b1;
        end else if (|grant) begin
            last <= grant[1];
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two requesters share one ALU through an IDLE/EXEC/RESP FSM.
// Define ALU_ARB_ILLEGAL_OP_EN to report ops 10-15 on rsp_err_o.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req0_valid_i,
    output logic             req0_ready_o,
    input  logic [ALU_W-1:0] req0_rs1_i,
    input  logic [ALU_W-1:0] req0_rs2_i,
    input  logic [3:0]       req0_op_i,
    input  logic             req0_unsign_i,
    input  logic             req1_valid_i,
    output logic             req1_ready_o,
    input  logic [ALU_W-1:0] req1_rs1_i,
    input  logic [ALU_W-1:0] req1_rs2_i,
    input  logic [3:0]       req1_op_i,
    input  logic             req1_unsign_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [ALU_W-1:0] rsp_data_o,
    output logic             rsp_id_o,
    output logic             rsp_err_o
);

    state_t               state;
    logic                 armed;
    logic                 arb_en;
    logic [NUM_REQ-1:0]   req_vec;
    logic [NUM_REQ-1:0]   grant;
    logic [ALU_W-1:0]     op_rs1;
    logic [ALU_W-1:0]     op_rs2;
    logic [3:0]           op_code;
    logic                 op_unsign;
    logic                 op_id;
    logic [ALU_W-1:0]     alu_result;
    logic                 alu_illegal;
    logic                 err_next;

    // armed blocks acceptance during the cycle in which reset is released.
    assign arb_en  = (state == IDLE) && armed;
    assign req_vec = {req1_valid_i, req0_valid_i};

    rr_arb2 u_arb (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .en    (arb_en),
        .req   (req_vec),
        .grant (grant)
    );

    assign req0_ready_o = grant[0];
    assign req1_ready_o = grant[1];

    alu u_alu (
        .op      (op_code),
        .a       (op_rs1),
        .b       (op_rs2),
        .unsign  (op_unsign),
        .result  (alu_result),
        .illegal (alu_illegal)
    );

`ifdef ALU_ARB_ILLEGAL_OP_EN
    assign err_next = alu_illegal;
`else
    logic unused_illegal;
    assign unused_illegal = alu_illegal;
    assign err_next       = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            armed       <= 1'b0;
            op_rs1      <= '0;
            op_rs2      <= '0;
            op_code     <= OP_ADD;
            op_unsign   <= 1'b0;
            op_id       <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= '0;
            rsp_id_o    <= 1'b0;
            rsp_err_o   <= 1'b0;
        end else begin
            armed <= 1'b1;
            case (state)
                IDLE: begin
                    if (|grant) begin
                        op_rs1    <= grant[1] ? req1_rs1_i    : req0_rs1_i;
                        op_rs2    <= grant[1] ? req1_rs2_i    : req0_rs2_i;
                        op_code   <= grant[1] ? req1_op_i     : req0_op_i;
                        op_unsign <= grant[1] ? req1_unsign_i : req0_unsign_i;
                        op_id     <= grant[1];
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data_o  <= alu_result;
                    rsp_id_o    <= op_id;
                    rsp_err_o   <= err_next;
                    rsp_valid_o <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
